fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and the fetch FSM state encoding.
package riscv_fetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] RESET_PC     = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two ring with a registered head entry that only
// changes on a pop or on a push into an empty buffer.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full  && !clear;
    assign do_pop  = pop  && !empty && !clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            // The entry behind the head is already in mem; otherwise the new
            // push becomes the head directly.
            if (do_pop && (count > CW'(1))) begin
                head_data <= mem[rd_ptr + AW'(1)];
            end else if (do_push && (empty || do_pop)) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, flush handling, buffer.
// Optional build macro FETCH_MISALIGN_CHECK_EN enables the misaligned-PC guard.
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_misalign,
    output fetch_state_e    state_dbg
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // imem handshake: a request is taken in the cycle imem_req is high (no
    // grant); its single response arrives later as a one-cycle imem_rvalid.
    // Decode handshake: an entry moves when instr_valid && instr_ready.
    fetch_state_e    state;
    fetch_state_e    next_state;
    logic [XLEN-1:0] req_pc;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pc_aligned;
    logic            room_after_push;
    logic            issue;
    logic            push;
    logic            clear;
    logic            pop;
    logic [2*XLEN-1:0] head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign pc_aligned     = (pc_in[1:0] == 2'b00);
    assign fetch_misalign = misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (flush) begin
            misalign_q <= 1'b0;
        end else if (state == IDLE && !pc_aligned) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign pc_aligned     = 1'b1;
    assign fetch_misalign = 1'b0;
`endif

    // Conservative: a pop in the same cycle is not counted as free space.
    assign room_after_push = (int'(fifo_count) + 1) < FIFO_DEPTH;

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        clear = 1'b1;
                    end else if (!fifo_full && pc_aligned) begin
                        issue      = 1'b1;
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        clear      = 1'b1;
                        next_state = imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        push = 1'b1;
                        if (room_after_push && pc_aligned) begin
                            issue = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                DROP: begin
                    clear = flush;
                    // The stale response retires DROP even if flush repeats.
                    if (imem_rvalid) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req_pc <= XLEN'(RESET_PC);
        end else begin
            state <= next_state;
            if (issue) begin
                req_pc <= pc_in;
            end
        end
    end

    assign imem_req  = issue;
    assign pc_en     = issue;
    assign imem_addr = issue ? pc_in : '0;
    assign state_dbg = state;

    assign pop         = instr_valid && instr_ready;
    assign instr_valid = !fifo_empty;
    assign instr       = head[2*XLEN-1:XLEN];
    assign instr_pc    = head[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data ({imem_rdata, req_pc}),
        .pop       (pop),
        .clear     (clear),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
